// File: rtl/alu_issue_if.sv
// Handshake and data bundle between the decode/issue stage, its upstream
// fetch/register-read logic and the downstream ALU.
// The master drives instructions in and consumes issued entries; the slave is
// the issue stage itself.
interface alu_issue_if;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_dataa;
    logic [31:0] out_datab;
    logic [3:0]  out_aluctr;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic        out_illegal;

    modport master (
        output flush, in_valid, in_pc, in_instr, in_rs1_data, in_rs2_data,
               fwd_valid, fwd_rd, fwd_data, out_ready,
        input  in_ready, out_valid, out_dataa, out_datab, out_aluctr,
               out_rd, out_rd_we, out_illegal
    );

    modport slave (
        input  flush, in_valid, in_pc, in_instr, in_rs1_data, in_rs2_data,
               fwd_valid, fwd_rd, fwd_data, out_ready,
        output in_ready, out_valid, out_dataa, out_datab, out_aluctr,
               out_rd, out_rd_we, out_illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Decode/issue register in front of the 32-bit ALU. Decodes one RV32I
// instruction, picks operands (with an optional writeback bypass), builds the
// ALU control code and holds the result in a single valid/ready slot.
module alu_issue_stage #(
    parameter bit FWD_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    alu_issue_if.slave  bus
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b1000;
    localparam logic [3:0] ALU_SLL   = 4'b0001;
    localparam logic [3:0] ALU_SLT   = 4'b0010;
    localparam logic [3:0] ALU_SLTU  = 4'b1010;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_SRA   = 4'b1101;
    localparam logic [3:0] ALU_OR    = 4'b0110;
    localparam logic [3:0] ALU_AND   = 4'b0111;
    localparam logic [3:0] ALU_PASSB = 4'b0011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Instruction fields
    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [6:0]  w_funct7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_u;
    logic [31:0] w_shamt;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;

    // Decoded entry
    logic        w_legal;
    logic [31:0] w_dataa;
    logic [31:0] w_datab;
    logic [3:0]  w_aluctr;
    logic        w_in_ready;
    logic        w_capture;

    // Issued entry
    logic        r_valid;
    logic [31:0] r_dataa;
    logic [31:0] r_datab;
    logic [3:0]  r_aluctr;
    logic [4:0]  r_rd;
    logic        r_rd_we;
    logic        r_illegal;

    assign w_opcode = bus.in_instr[6:0];
    assign w_rd     = bus.in_instr[11:7];
    assign w_funct3 = bus.in_instr[14:12];
    assign w_rs1    = bus.in_instr[19:15];
    assign w_rs2    = bus.in_instr[24:20];
    assign w_funct7 = bus.in_instr[31:25];
    assign w_imm_i  = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
    assign w_imm_u  = {bus.in_instr[31:12], 12'b0};
    assign w_shamt  = {27'b0, bus.in_instr[24:20]};

    // x0 always reads zero; a matching writeback in the same cycle overrides the
    // stale register-file value when the bypass is built in.
    function automatic logic [31:0] read_operand(input logic [4:0]  idx,
                                                 input logic [31:0] rf_data,
                                                 input logic        fwd_valid,
                                                 input logic [4:0]  fwd_rd,
                                                 input logic [31:0] fwd_data);
        logic [31:0] val;
        if (idx == 5'd0)
            val = 32'd0;
        else if (FWD_EN && fwd_valid && (fwd_rd == idx))
            val = fwd_data;
        else
            val = rf_data;
        return val;
    endfunction

    // funct3 to ALU code; alt selects SUB/SRA on the two funct3 values that have one.
    function automatic logic [3:0] funct_code(input logic [2:0] f3, input logic alt);
        logic [3:0] code;
        case (f3)
            3'b000:  code = alt ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = alt ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

    assign w_rs1_val = read_operand(w_rs1, bus.in_rs1_data, bus.fwd_valid, bus.fwd_rd, bus.fwd_data);
    assign w_rs2_val = read_operand(w_rs2, bus.in_rs2_data, bus.fwd_valid, bus.fwd_rd, bus.fwd_data);

    // Decode opcode/funct into operands and ALU code; illegal forms collapse to ADD 0,0.
    always_comb begin
        w_legal  = 1'b0;
        w_dataa  = 32'd0;
        w_datab  = 32'd0;
        w_aluctr = ALU_ADD;
        case (w_opcode)
            OPC_OP: begin
                w_legal  = (w_funct7 == F7_ZERO) ||
                           ((w_funct7 == F7_ALT) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
                w_dataa  = w_rs1_val;
                w_datab  = w_rs2_val;
                w_aluctr = funct_code(w_funct3, w_funct7[5]);
            end
            OPC_OP_IMM: begin
                w_dataa = w_rs1_val;
                case (w_funct3)
                    3'b001: begin
                        w_legal  = (w_funct7 == F7_ZERO);
                        w_datab  = w_shamt;
                        w_aluctr = ALU_SLL;
                    end
                    3'b101: begin
                        w_legal  = (w_funct7 == F7_ZERO) || (w_funct7 == F7_ALT);
                        w_datab  = w_shamt;
                        w_aluctr = funct_code(w_funct3, w_funct7[5]);
                    end
                    default: begin
                        // funct7 bits are immediate here, so no SUB form exists
                        w_legal  = 1'b1;
                        w_datab  = w_imm_i;
                        w_aluctr = funct_code(w_funct3, 1'b0);
                    end
                endcase
            end
            OPC_LUI: begin
                w_legal  = 1'b1;
                w_dataa  = 32'd0;
                w_datab  = w_imm_u;
                w_aluctr = ALU_PASSB;
            end
            OPC_AUIPC: begin
                w_legal  = 1'b1;
                w_dataa  = bus.in_pc;
                w_datab  = w_imm_u;
                w_aluctr = ALU_ADD;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
        if (!w_legal) begin
            w_dataa  = 32'd0;
            w_datab  = 32'd0;
            w_aluctr = ALU_ADD;
        end
    end

    assign w_in_ready = !rst && !bus.flush && (!r_valid || bus.out_ready);
    assign w_capture  = bus.in_valid && w_in_ready;

    // Output slot: flush empties it, capture loads it (including back-to-back), consume drains it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_dataa   <= 32'd0;
            r_datab   <= 32'd0;
            r_aluctr  <= 4'd0;
            r_rd      <= 5'd0;
            r_rd_we   <= 1'b0;
            r_illegal <= 1'b0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid   <= 1'b1;
            r_dataa   <= w_dataa;
            r_datab   <= w_datab;
            r_aluctr  <= w_aluctr;
            r_rd      <= w_rd;
            r_rd_we   <= w_legal && (w_rd != 5'd0);
            r_illegal <= !w_legal;
        end else if (bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_valid;
    assign bus.out_dataa   = r_dataa;
    assign bus.out_datab   = r_datab;
    assign bus.out_aluctr  = r_aluctr;
    assign bus.out_rd      = r_rd;
    assign bus.out_rd_we   = r_rd_we;
    assign bus.out_illegal = r_illegal;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: a bypass-enabled and a bypass-disabled instance
// receive identical stimulus and are compared against a mnemonic-level model.
module tb_alu_issue_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vecs = 0;
    int   miss = 0;

    always #5 clk = ~clk;

    alu_issue_if b1();
    alu_issue_if b0();

    alu_issue_stage #(.FWD_EN(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));
    alu_issue_stage #(.FWD_EN(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus(b0));

    // Model state of each instance's output slot (index 1 = bypass on)
    logic        m_v  [2];
    logic [31:0] m_a  [2];
    logic [31:0] m_b  [2];
    logic [3:0]  m_c  [2];
    logic [4:0]  m_rd [2];
    logic        m_we [2];
    logic        m_il [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic string f3_name(input logic [2:0] f3);
        case (f3)
            3'd0: return "add";
            3'd1: return "sll";
            3'd2: return "slt";
            3'd3: return "sltu";
            3'd4: return "xor";
            3'd5: return "srl";
            3'd6: return "or";
            default: return "and";
        endcase
    endfunction

    function automatic logic [3:0] mn_code(input string mn);
        case (mn)
            "sub":   return 4'b1000;
            "sll":   return 4'b0001;
            "slt":   return 4'b0010;
            "sltu":  return 4'b1010;
            "xor":   return 4'b0100;
            "srl":   return 4'b0101;
            "sra":   return 4'b1101;
            "or":    return 4'b0110;
            "and":   return 4'b0111;
            "passb": return 4'b0011;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] ref_reg(input bit fwd_en, input logic [4:0] idx, input logic [31:0] rf,
                                            input logic fv, input logic [4:0] frd, input logic [31:0] fd);
        if (idx == 0) return 32'd0;
        if (fwd_en && fv && frd == idx) return fd;
        return rf;
    endfunction

    // Loads model slot k with the issued form of one instruction.
    task automatic ref_issue(input int k, input logic [31:0] pc, input logic [31:0] ins,
                             input logic [31:0] d1, input logic [31:0] d2,
                             input logic fv, input logic [4:0] frd, input logic [31:0] fd);
        string       mn;
        logic [31:0] r1, r2, a, b;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        r1 = ref_reg(k == 1, ins[19:15], d1, fv, frd, fd);
        r2 = ref_reg(k == 1, ins[24:20], d2, fv, frd, fd);
        mn = "ILL";
        a = 0;
        b = 0;
        if (op == 7'h33) begin
            a = r1;
            b = r2;
            if (f7 == 7'h00) mn = f3_name(f3);
            else if (f7 == 7'h20 && f3 == 3'd0) mn = "sub";
            else if (f7 == 7'h20 && f3 == 3'd5) mn = "sra";
        end else if (op == 7'h13) begin
            a = r1;
            if (f3 == 3'd1 || f3 == 3'd5) begin
                b = 32'(ins[24:20]);
                if (f7 == 7'h00) mn = f3_name(f3);
                else if (f7 == 7'h20 && f3 == 3'd5) mn = "sra";
            end else begin
                b = 32'($signed(ins[31:20]));
                mn = f3_name(f3);
            end
        end else if (op == 7'h37) begin
            mn = "passb";
            a = 0;
            b = ins & 32'hFFFF_F000;
        end else if (op == 7'h17) begin
            mn = "add";
            a = pc;
            b = ins & 32'hFFFF_F000;
        end
        m_v[k]  = 1'b1;
        m_rd[k] = ins[11:7];
        m_il[k] = (mn == "ILL");
        m_we[k] = (mn != "ILL") && (ins[11:7] != 0);
        m_a[k]  = m_il[k] ? 32'd0 : a;
        m_b[k]  = m_il[k] ? 32'd0 : b;
        m_c[k]  = mn_code(mn);
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            string p;
            logic ov, we, il;
            logic [31:0] a, b;
            logic [3:0] c;
            logic [4:0] rd;
            p  = (k == 1) ? "fwd1" : "fwd0";
            ov = (k == 1) ? b1.out_valid   : b0.out_valid;
            a  = (k == 1) ? b1.out_dataa   : b0.out_dataa;
            b  = (k == 1) ? b1.out_datab   : b0.out_datab;
            c  = (k == 1) ? b1.out_aluctr  : b0.out_aluctr;
            rd = (k == 1) ? b1.out_rd      : b0.out_rd;
            we = (k == 1) ? b1.out_rd_we   : b0.out_rd_we;
            il = (k == 1) ? b1.out_illegal : b0.out_illegal;
            chk({p, ".out_valid"}, 32'(ov), 32'(m_v[k]));
            if (m_v[k]) begin
                chk({p, ".dataa"}, a, m_a[k]);
                chk({p, ".datab"}, b, m_b[k]);
                chk({p, ".aluctr"}, 32'(c), 32'(m_c[k]));
                chk({p, ".rd"}, 32'(rd), 32'(m_rd[k]));
                chk({p, ".rd_we"}, 32'(we), 32'(m_we[k]));
                chk({p, ".illegal"}, 32'(il), 32'(m_il[k]));
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_v[k] = 0; m_a[k] = 0; m_b[k] = 0; m_c[k] = 0;
            m_rd[k] = 0; m_we[k] = 0; m_il[k] = 0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".valid1"}, 32'(b1.out_valid), 0);
        chk({tag, ".valid0"}, 32'(b0.out_valid), 0);
        chk({tag, ".ready1"}, 32'(b1.in_ready), 0);
        chk({tag, ".dataa"}, b1.out_dataa | b0.out_dataa, 0);
        chk({tag, ".datab"}, b1.out_datab | b0.out_datab, 0);
        chk({tag, ".misc"}, {b1.out_aluctr, b1.out_rd, b1.out_rd_we, b1.out_illegal,
                             b0.out_aluctr, b0.out_rd, b0.out_rd_we, b0.out_illegal}, 0);
    endtask

    // One clock: drive inputs after negedge, check in_ready, model the edge, check outputs.
    task automatic step(input logic fl, input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                        input logic [31:0] d1, input logic [31:0] d2, input logic fv,
                        input logic [4:0] frd, input logic [31:0] fd, input logic ordy);
        logic rdy [2];
        b1.flush = fl; b1.in_valid = iv; b1.in_pc = pc; b1.in_instr = ins;
        b1.in_rs1_data = d1; b1.in_rs2_data = d2; b1.fwd_valid = fv; b1.fwd_rd = frd;
        b1.fwd_data = fd; b1.out_ready = ordy;
        b0.flush = fl; b0.in_valid = iv; b0.in_pc = pc; b0.in_instr = ins;
        b0.in_rs1_data = d1; b0.in_rs2_data = d2; b0.fwd_valid = fv; b0.fwd_rd = frd;
        b0.fwd_data = fd; b0.out_ready = ordy;
        #1;
        for (int k = 0; k < 2; k++) begin
            rdy[k] = !fl && (!m_v[k] || ordy);
            chk((k == 1) ? "fwd1.in_ready" : "fwd0.in_ready",
                32'((k == 1) ? b1.in_ready : b0.in_ready), 32'(rdy[k]));
        end
        $display("step pc=%08h instr=%08h in_valid=%0d flush=%0d out_ready=%0d", pc, ins, iv, fl, ordy);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (fl) m_v[k] = 1'b0;
            else if (iv && rdy[k]) ref_issue(k, pc, ins, d1, d2, fv, frd, fd);
            else if (ordy) m_v[k] = 1'b0;
        end
        @(negedge clk);
        check_outputs();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [4:0]  rd, r1, r2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        rd = 5'($urandom_range(0, 7));
        r1 = 5'($urandom_range(0, 3));
        r2 = 5'($urandom_range(0, 3));
        f3 = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 6))
            0: w = {7'h00, r2, r1, f3, rd, 7'h33};
            1: w = {7'h20, r2, r1, f3, rd, 7'h33};
            2: w = {7'($urandom), r2, r1, f3, rd, 7'h33};
            3: w = {12'($urandom), r1, f3, rd, 7'h13};
            4: begin
                case ($urandom_range(0, 2))
                    0: f7 = 7'h00;
                    1: f7 = 7'h20;
                    default: f7 = 7'($urandom);
                endcase
                w = {f7, r2, r1, ($urandom_range(0, 1) != 0) ? 3'd1 : 3'd5, rd, 7'h13};
            end
            5: w = {20'($urandom), rd, ($urandom_range(0, 1) != 0) ? 7'h37 : 7'h17};
            default: w = $urandom;
        endcase
        return w;
    endfunction

    initial begin
        model_reset();
        b1.flush = 0; b1.in_valid = 0; b1.in_pc = 0; b1.in_instr = 0; b1.in_rs1_data = 0;
        b1.in_rs2_data = 0; b1.fwd_valid = 0; b1.fwd_rd = 0; b1.fwd_data = 0; b1.out_ready = 0;
        b0.flush = 0; b0.in_valid = 0; b0.in_pc = 0; b0.in_instr = 0; b0.in_rs1_data = 0;
        b0.in_rs2_data = 0; b0.fwd_valid = 0; b0.fwd_rd = 0; b0.fwd_data = 0; b0.out_ready = 0;

        // Reset state
        #2;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // add x3,x1,x2
        step(0, 1, 32'h100, 32'h002081B3, 32'd5, 32'd7, 0, 0, 0, 1);
        chk("s1.dataa", b1.out_dataa, 32'd5);
        chk("s1.datab", b1.out_datab, 32'd7);
        chk("s1.aluctr", 32'(b1.out_aluctr), 32'h0);
        chk("s1.rd", 32'(b1.out_rd), 32'd3);
        chk("s1.we", 32'(b1.out_rd_we), 32'd1);

        // srai, sub, lui
        step(0, 1, 32'h104, 32'h4030D213, 32'h8000_0000, 32'h0, 0, 0, 0, 1);
        chk("srai.datab", b1.out_datab, 32'd3);
        chk("srai.aluctr", 32'(b1.out_aluctr), 32'hD);
        step(0, 1, 32'h108, 32'h402081B3, 32'd9, 32'd4, 0, 0, 0, 1);
        chk("sub.aluctr", 32'(b1.out_aluctr), 32'h8);
        step(0, 1, 32'h10C, 32'h123452B7, 32'd1, 32'd2, 0, 0, 0, 1);
        chk("lui.dataa", b1.out_dataa, 32'h0);
        chk("lui.datab", b1.out_datab, 32'h1234_5000);
        chk("lui.aluctr", 32'(b1.out_aluctr), 32'h3);

        // Backpressure: hold four cycles, then back-to-back transfer
        step(0, 1, 32'h110, 32'h002081B3, 32'd11, 32'd12, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            step(0, 1, 32'h114, 32'h402081B3, 32'd20, 32'd3, 0, 0, 0, 0);
        step(0, 1, 32'h114, 32'h402081B3, 32'd20, 32'd3, 0, 0, 0, 1);
        chk("b2b.aluctr", 32'(b1.out_aluctr), 32'h8);

        // Bypass on x1, x0 operand
        step(0, 1, 32'h118, 32'h000081B3, 32'h1111, 32'h2222, 1, 5'd1, 32'hDEAD, 1);
        chk("fwd.dataa1", b1.out_dataa, 32'hDEAD);
        chk("fwd.dataa0", b0.out_dataa, 32'h1111);
        chk("fwd.datab", b1.out_datab, 32'h0);

        // Flush beats capture; then an unsupported opcode
        step(1, 1, 32'h11C, 32'h123452B7, 0, 0, 0, 0, 0, 0);
        chk("flush.valid", 32'(b1.out_valid), 32'd0);
        step(0, 1, 32'h120, 32'h0000A303, 32'd4, 32'd4, 0, 0, 0, 1);
        chk("ill.illegal", 32'(b1.out_illegal), 32'd1);
        chk("ill.we", 32'(b1.out_rd_we), 32'd0);

        // Asynchronous reset in the middle of a hold
        step(0, 1, 32'h124, 32'h00000217, 0, 0, 0, 0, 0, 1);
        step(0, 1, 32'h128, 32'h002081B3, 1, 2, 0, 0, 0, 0);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(0, 1, 32'h100, 32'h002081B3, 32'd5, 32'd7, 0, 0, 0, 1);
        chk("post_rst.dataa", b1.out_dataa, 32'd5);
        chk("post_rst.datab", b1.out_datab, 32'd7);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), $urandom, rand_instr(),
                 $urandom, $urandom, ($urandom_range(0, 1) != 0), 5'($urandom_range(0, 3)),
                 $urandom, ($urandom_range(0, 2) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
